display_scan_mux: RTL and testbench

Time-multiplexed display driver for the six-digit clock display. It sits downstream of the second, minute and hour counters and their digit outputs. It takes the six 4-bit BCD digits and drives one shared 7-segment bus plus six one-hot digit enables, scanning one digit at a time. It also provides inter-digit ghost blanking, blinking of the field being set, hour leading-zero suppression and colon dots.

---
 rtl/display_scan_mux.sv | 82 ++++++++
 tb/tb_display_scan_mux.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: six-digit 7-seg scan driver with ghost blanking, field blink, hour leading-zero suppression and colon (ports: clk, reset, six BCD digits, set_sw, blink_sel, lz_en -> seg_out, dig_en, dp_out)
module display_scan_mux #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 2,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_sec0,
  input  logic [3:0] digit_sec1,
  input  logic [3:0] digit_min0,
  input  logic [3:0] digit_min1,
  input  logic [3:0] digit_hour0,
  input  logic [3:0] digit_hour1,
  input  logic       set_sw,
  input  logic [1:0] blink_sel,
  input  logic       lz_en,
  output logic [6:0] seg_out,
  output logic [5:0] dig_en,
  output logic       dp_out
);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV);
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          blink_phase_q, blink_phase_d;
  logic [6:0]    seg_q, seg_d, dec;
  logic [5:0]    dig_q, dig_d;
  logic          dp_q, dp_d, blank;
  logic [3:0]    d;
  always_comb begin
    scan_cnt_d    = scan_cnt_q == SW'(SCAN_DIV - 1) ? '0 : scan_cnt_q + 1'b1;
    idx_d         = scan_cnt_q != SW'(SCAN_DIV - 1) ? idx_q : idx_q == 3'd5 ? 3'd0 : idx_q + 3'd1;
    blink_cnt_d   = blink_cnt_q == BW'(BLINK_DIV - 1) ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_cnt_q == BW'(BLINK_DIV - 1) ? ~blink_phase_q : blink_phase_q;
    d = idx_q == 3'd0 ? digit_sec0 : idx_q == 3'd1 ? digit_sec1 :
        idx_q == 3'd2 ? digit_min0 : idx_q == 3'd3 ? digit_min1 :
        idx_q == 3'd4 ? digit_hour0 : digit_hour1;
    case (d)
      4'd0:    dec = 7'h3F;
      4'd1:    dec = 7'h06;
      4'd2:    dec = 7'h5B;
      4'd3:    dec = 7'h4F;
      4'd4:    dec = 7'h66;
      4'd5:    dec = 7'h6D;
      4'd6:    dec = 7'h7D;
      4'd7:    dec = 7'h07;
      4'd8:    dec = 7'h7F;
      4'd9:    dec = 7'h6F;
      default: dec = 7'h40;
    endcase
    // idx[2:1] is the field number: 0 seconds, 1 minutes, 2 hours; blink_sel is that plus one
    blank = (set_sw & blink_phase_q & (blink_sel != 2'd0) & (idx_q[2:1] == 2'(blink_sel - 2'd1)))
          | (lz_en & (idx_q == 3'd5) & (digit_hour1 == 4'd0));
    seg_d = blank ? 7'h00 : dec;
    dig_d = scan_cnt_q < SW'(BLANK_CYC) ? 6'b0 : 6'b1 << idx_q;
    dp_d  = (idx_q == 3'd2 || idx_q == 3'd4) & (set_sw | ~blink_phase_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= '0;
      dig_q         <= '0;
      dp_q          <= 1'b0;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      dig_q         <= dig_d;
      dp_q          <= dp_d;
    end
  end
  assign seg_out = seg_q;
  assign dig_en  = dig_q;
  assign dp_out  = dp_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: directed bench for display_scan_mux with SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=8
module tb_display_scan_mux;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit_sec0, digit_sec1, digit_min0, digit_min1, digit_hour0, digit_hour1;
  logic       set_sw = 1'b0;
  logic [1:0] blink_sel = 2'b00;
  logic       lz_en = 1'b0;
  logic [6:0] seg_out;
  logic [5:0] dig_en;
  logic       dp_out;
  int         pass_cnt = 0;
  int         total = 0;
  logic [6:0] sg [6] = '{7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  display_scan_mux #(.SCAN_DIV(4), .BLANK_CYC(1), .BLINK_DIV(8)) dut (
    .clk(clk), .reset(reset),
    .digit_sec0(digit_sec0), .digit_sec1(digit_sec1),
    .digit_min0(digit_min0), .digit_min1(digit_min1),
    .digit_hour0(digit_hour0), .digit_hour1(digit_hour1),
    .set_sw(set_sw), .blink_sel(blink_sel), .lz_en(lz_en),
    .seg_out(seg_out), .dig_en(dig_en), .dp_out(dp_out)
  );
  always #5 clk = ~clk;
  // Sample j is taken at the negedge j cycles after the reset edge; j>=1 reflects state t=j-1:
  // scan_cnt = t%4, idx = (t/4)%6, blink_phase = (t/8)%2.
  function automatic logic [5:0] exp_den(int j);
    if (j == 0 || (j - 1) % 4 < 1) return 6'b0;
    return 6'b1 << (((j - 1) / 4) % 6);
  endfunction
  function automatic int ix_of(int j);
    return ((j - 1) / 4) % 6;
  endfunction
  function automatic logic ph_of(int j);
    return 1'((((j - 1) / 8) % 2));
  endfunction
  function automatic logic exp_dp(int j, logic s);
    if (j == 0) return 1'b0;
    return (ix_of(j) == 2 || ix_of(j) == 4) && (s || !ph_of(j));
  endfunction
  task automatic set_digits(input logic [3:0] a, b, c, e, f, g);
    digit_sec0 = a; digit_sec1 = b; digit_min0 = c;
    digit_min1 = e; digit_hour0 = f; digit_hour1 = g;
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    set_digits(5, 4, 3, 2, 1, 0);
    set_sw = 0; lz_en = 0; blink_sel = 0;
    do_reset();
    repeat (7) @(negedge clk);
    do_reset();
    total++;
    if ({seg_out, dig_en, dp_out} !== 14'b0)
      $display("FAIL reset: seg=%h dig=%b dp=%b required 00/000000/0", seg_out, dig_en, dp_out);
    else pass_cnt++;
  endtask
  task automatic test_scan();
    set_digits(5, 4, 3, 2, 1, 0);
    set_sw = 0; lz_en = 0; blink_sel = 0;
    do_reset();
    for (int j = 0; j <= 28; j++) begin
      if (j > 0) @(negedge clk);
      total++;
      if (dig_en !== exp_den(j)) $display("FAIL scan_dig j=%0d: got %b required %b", j, dig_en, exp_den(j));
      else pass_cnt++;
      if (exp_den(j) != 0) begin
        total++;
        if (seg_out !== sg[ix_of(j)]) $display("FAIL scan_seg j=%0d: got %h required %h", j, seg_out, sg[ix_of(j)]);
        else pass_cnt++;
      end
      total++;
      if (dp_out !== exp_dp(j, 1'b0)) $display("FAIL scan_dp j=%0d: got %b required %b", j, dp_out, exp_dp(j, 1'b0));
      else pass_cnt++;
    end
  endtask
  task automatic test_lz();
    set_digits(5, 4, 3, 2, 1, 0);
    set_sw = 0; lz_en = 1; blink_sel = 0;
    do_reset();
    repeat (18) @(negedge clk);
    total++;
    if (seg_out !== 7'h06 || dig_en !== 6'b010000) $display("FAIL lz_hour0: seg=%h dig=%b required 06/010000", seg_out, dig_en);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    total++;
    if (seg_out !== 7'h00 || dig_en !== 6'b100000) $display("FAIL lz_blank: seg=%h dig=%b required 00/100000", seg_out, dig_en);
    else pass_cnt++;
    digit_hour1 = 1;
    @(negedge clk);
    total++;
    if (seg_out !== 7'h06 || dig_en !== 6'b100000) $display("FAIL lz_one: seg=%h dig=%b required 06/100000", seg_out, dig_en);
    else pass_cnt++;
    lz_en = 0;
    digit_hour1 = 0;
  endtask
  task automatic test_blink();
    logic [6:0] es;
    set_digits(5, 4, 3, 2, 1, 0);
    set_sw = 1; lz_en = 0; blink_sel = 2'b10;
    do_reset();
    for (int j = 1; j <= 48; j++) begin
      @(negedge clk);
      total++;
      if (dig_en !== exp_den(j)) $display("FAIL blink_dig j=%0d: got %b required %b", j, dig_en, exp_den(j));
      else pass_cnt++;
      if (exp_den(j) != 0) begin
        es = (ph_of(j) && (ix_of(j) == 2 || ix_of(j) == 3)) ? 7'h00 : sg[ix_of(j)];
        total++;
        if (seg_out !== es) $display("FAIL blink_seg j=%0d: got %h required %h", j, seg_out, es);
        else pass_cnt++;
      end
      total++;
      if (dp_out !== exp_dp(j, 1'b1)) $display("FAIL blink_dp j=%0d: got %b required %b", j, dp_out, exp_dp(j, 1'b1));
      else pass_cnt++;
    end
  endtask
  task automatic test_blink_disable();
    set_digits(5, 4, 3, 2, 1, 0);
    lz_en = 0;
    for (int m = 0; m < 2; m++) begin
      set_sw = (m == 0);
      blink_sel = (m == 0) ? 2'b00 : 2'b11;
      do_reset();
      for (int j = 1; j <= 24; j++) begin
        @(negedge clk);
        if (exp_den(j) != 0) begin
          total++;
          if (seg_out !== sg[ix_of(j)]) $display("FAIL noblink_seg m=%0d j=%0d: got %h required %h", m, j, seg_out, sg[ix_of(j)]);
          else pass_cnt++;
        end
      end
    end
  endtask
  task automatic test_illegal();
    set_digits(5, 4, 12, 2, 1, 0);
    set_sw = 0; lz_en = 0; blink_sel = 0;
    do_reset();
    for (int j = 1; j <= 36; j++) begin
      @(negedge clk);
      if (ix_of(j) == 2 && exp_den(j) != 0) begin
        total++;
        if (seg_out !== 7'h40) $display("FAIL illegal_seg j=%0d: got %h required 40", j, seg_out);
        else pass_cnt++;
        total++;
        if (dp_out !== exp_dp(j, 1'b0)) $display("FAIL illegal_dp j=%0d: got %b required %b", j, dp_out, exp_dp(j, 1'b0));
        else pass_cnt++;
      end
    end
  endtask
  task automatic test_mid_reset();
    set_digits(5, 4, 3, 2, 1, 0);
    set_sw = 0; lz_en = 0; blink_sel = 0;
    do_reset();
    repeat (15) @(negedge clk);
    total++;
    if (dig_en !== 6'b001000) $display("FAIL mid_pre: dig=%b required 001000", dig_en);
    else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if ({seg_out, dig_en, dp_out} !== 14'b0)
      $display("FAIL mid_reset: seg=%h dig=%b dp=%b required 00/000000/0", seg_out, dig_en, dp_out);
    else pass_cnt++;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      total++;
      if (dig_en !== exp_den(j) || dp_out !== exp_dp(j, 1'b0))
        $display("FAIL mid_restart j=%0d: dig=%b dp=%b required %b/%b", j, dig_en, dp_out, exp_den(j), exp_dp(j, 1'b0));
      else pass_cnt++;
    end
  endtask
  initial begin
    set_digits(0, 0, 0, 0, 0, 0);
    test_reset();
    test_scan();
    test_lz();
    test_blink();
    test_blink_disable();
    test_illegal();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
